// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// Optional statistics counters (stat_ops, stat_stall) are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*XLEN-1:0] req_in1,
    input  logic [NUM_REQ*XLEN-1:0] req_in2,
    input  logic [NUM_REQ*3-1:0]    req_f3,
    input  logic [NUM_REQ*7-1:0]    req_f7,
    input  logic [NUM_REQ*7-1:0]    req_opcode,
    output logic [XLEN-1:0]         alu_in1,
    output logic [XLEN-1:0]         alu_in2,
    output logic [2:0]              alu_f3,
    output logic [6:0]              alu_f7,
    output logic [6:0]              alu_opcode,
    input  logic [XLEN-1:0]         alu_result,
    input  logic                    alu_zero,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [XLEN-1:0]         resp_result,
    output logic                    resp_zero,
`ifdef ALU_ARB_STATS_EN
    output logic [31:0]             stat_ops,
    output logic [31:0]             stat_stall,
`endif
    output logic                    busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic [XLEN-1:0]    in1_q, in2_q;
    logic [2:0]         f3_q;
    logic [6:0]         f7_q, opcode_q;
    logic [XLEN-1:0]    result_q;
    logic               zero_q;

    logic [XLEN-1:0]    in1_arr [NUM_REQ];
    logic [XLEN-1:0]    in2_arr [NUM_REQ];
    logic [2:0]         f3_arr  [NUM_REQ];
    logic [6:0]         f7_arr  [NUM_REQ];
    logic [6:0]         op_arr  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign in1_arr[gi] = req_in1[gi*XLEN +: XLEN];
            assign in2_arr[gi] = req_in2[gi*XLEN +: XLEN];
            assign f3_arr[gi]  = req_f3[gi*3 +: 3];
            assign f7_arr[gi]  = req_f7[gi*7 +: 7];
            assign op_arr[gi]  = req_opcode[gi*7 +: 7];
        end
    endgenerate

    // Rotating priority: search starts just after the last granted requester.
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    int unsigned      cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    logic accept;
    logic resp_done;

    assign accept    = (state_q == IDLE) && grant_found;
    assign resp_done = (state_q == RESP) && resp_ready[owner_q];

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = '0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so req_ready stays low while reset is held.
                if (grant_found && rst_n) begin
                    req_ready[grant_idx] = 1'b1;
                end
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            in1_q        <= '0;
            in2_q        <= '0;
            f3_q         <= '0;
            f7_q         <= '0;
            opcode_q     <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant_idx;
                last_grant_q <= grant_idx;
                in1_q        <= in1_arr[grant_idx];
                in2_q        <= in2_arr[grant_idx];
                f3_q         <= f3_arr[grant_idx];
                f7_q         <= f7_arr[grant_idx];
                opcode_q     <= op_arr[grant_idx];
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_ops_q, stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (resp_done) begin
                stat_ops_q <= stat_ops_q + 32'd1;
            end
            if ((state_q == RESP) && !resp_ready[owner_q]) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_stall = stat_stall_q;
`endif

    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_f3      = f3_q;
    assign alu_f7      = f7_q;
    assign alu_opcode  = opcode_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and a small behavioural RV32 ALU.
// Stats checks are compiled in when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

    localparam int NR = 2;
    localparam int XL = 32;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*XL-1:0] req_in1, req_in2;
    logic [NR*3-1:0] req_f3;
    logic [NR*7-1:0] req_f7, req_opcode;
    logic [XL-1:0]   alu_in1, alu_in2;
    logic [2:0]      alu_f3;
    logic [6:0]      alu_f7, alu_opcode;
    logic [XL-1:0]   alu_result;
    logic            alu_zero;
    logic [NR-1:0]   resp_valid;
    logic [NR-1:0]   resp_ready;
    logic [XL-1:0]   resp_result;
    logic            resp_zero;
    logic            busy;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]     stat_ops, stat_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_f3     (req_f3),
        .req_f7     (req_f7),
        .req_opcode (req_opcode),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_f3     (alu_f3),
        .alu_f7     (alu_f7),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .resp_zero  (resp_zero),
`ifdef ALU_ARB_STATS_EN
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU (R-type subset).
    logic [XL-1:0] model_res;
    always_comb begin
        model_res = alu_in1 + alu_in2;
        if (alu_opcode == 7'h33) begin
            case (alu_f3)
                3'd0:    model_res = alu_f7[5] ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);
                3'd4:    model_res = alu_in1 ^ alu_in2;
                3'd6:    model_res = alu_in1 | alu_in2;
                3'd7:    model_res = alu_in1 & alu_in2;
                default: model_res = alu_in1 + alu_in2;
            endcase
        end
    end
    assign alu_result = model_res;
    assign alu_zero   = (model_res == '0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] op);
        req_in1[idx*XL +: XL]  = a;
        req_in2[idx*XL +: XL]  = b;
        req_f3[idx*3 +: 3]     = f3;
        req_f7[idx*7 +: 7]     = f7;
        req_opcode[idx*7 +: 7] = op;
        req_valid[idx]         = 1'b1;
    endtask

    // Runs one op from IDLE: accept, EXEC, RESP (with optional stall cycles), back to IDLE.
    task automatic run_op(input string tag, input int idx, input logic [1:0] exp_ready,
                          input logic [31:0] exp_in1, input logic [31:0] exp_res,
                          input logic exp_zero, input int stalls, input bit drop);
        logic [1:0] own;
        own = 2'b01 << idx;
        resp_ready = (stalls > 0) ? ~own : 2'b11;
        #1;
        check({tag, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
        check({tag, ".idle_busy"}, 64'(busy), 64'd0);
        tick();
        if (drop) req_valid[idx] = 1'b0;
        check({tag, ".exec_busy"}, 64'(busy), 64'd1);
        check({tag, ".exec_ready"}, 64'(req_ready), 64'd0);
        check({tag, ".exec_rvalid"}, 64'(resp_valid), 64'd0);
        check({tag, ".alu_in1"}, 64'(alu_in1), 64'(exp_in1));
        tick();
        check({tag, ".resp_valid"}, 64'(resp_valid), 64'(own));
        check({tag, ".resp_result"}, 64'(resp_result), 64'(exp_res));
        check({tag, ".resp_zero"}, 64'(resp_zero), 64'(exp_zero));
        for (int s = 0; s < stalls; s++) begin
            tick();
            check({tag, ".stall_valid"}, 64'(resp_valid), 64'(own));
            check({tag, ".stall_result"}, 64'(resp_result), 64'(exp_res));
            check({tag, ".stall_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 2'b11;
        tick();
        resp_ready = 2'b00;
        check({tag, ".done_busy"}, 64'(busy), 64'd0);
        check({tag, ".done_rvalid"}, 64'(resp_valid), 64'd0);
        $display("[TB] %s owner=%0d result=0x%08h zero=%0d stalls=%0d", tag, idx, exp_res, exp_zero, stalls);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_in1    = '0;
        req_in2    = '0;
        req_f3     = '0;
        req_f7     = '0;
        req_opcode = '0;
        resp_ready = '0;
        #3;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.req_ready", 64'(req_ready), 64'd0);
        check("rst.resp_valid", 64'(resp_valid), 64'd0);
        check("rst.resp_result", 64'(resp_result), 64'd0);
        check("rst.alu_in1", 64'(alu_in1), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single ADD on requester 0
        set_req(0, 32'd5, 32'd7, 3'd0, 7'h00, 7'h33);
        run_op("add", 0, 2'b01, 32'd5, 32'd12, 1'b0, 0, 1'b1);

        // SUB giving zero on requester 1
        set_req(1, 32'h10, 32'h10, 3'd0, 7'h20, 7'h33);
        run_op("sub_zero", 1, 2'b10, 32'h10, 32'd0, 1'b1, 0, 1'b1);

        // Round robin with both requesters held valid
        set_req(0, 32'hF0F0, 32'h0FF0, 3'd7, 7'h00, 7'h33);
        set_req(1, 32'h1200, 32'h0034, 3'd6, 7'h00, 7'h33);
        run_op("rr0", 0, 2'b01, 32'hF0F0, 32'h00F0, 1'b0, 0, 1'b0);
        run_op("rr1", 1, 2'b10, 32'h1200, 32'h1234, 1'b0, 0, 1'b0);
        run_op("rr2", 0, 2'b01, 32'hF0F0, 32'h00F0, 1'b0, 0, 1'b0);
        run_op("rr3", 1, 2'b10, 32'h1200, 32'h1234, 1'b0, 0, 1'b0);
        req_valid = '0;

        // Backpressure: owner stalls 5 cycles while requester 1 waits
        set_req(0, 32'd100, 32'd23, 3'd0, 7'h00, 7'h33);
        set_req(1, 32'hAA, 32'h0F, 3'd4, 7'h00, 7'h33);
        run_op("bp0", 0, 2'b01, 32'd100, 32'd123, 1'b0, 5, 1'b1);
        run_op("bp1", 1, 2'b10, 32'hAA, 32'hA5, 1'b0, 0, 1'b1);

        // Async reset during EXEC
        set_req(0, 32'd1, 32'd1, 3'd0, 7'h00, 7'h33);
        #1;
        check("arst.req_ready", 64'(req_ready), 64'b01);
        tick();
        check("arst.exec_busy", 64'(busy), 64'd1);
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("arst.busy", 64'(busy), 64'd0);
        check("arst.resp_valid", 64'(resp_valid), 64'd0);
        check("arst.req_ready", 64'(req_ready), 64'd0);
        check("arst.alu_in1", 64'(alu_in1), 64'd0);
        check("arst.resp_result", 64'(resp_result), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst.no_stale", 64'(resp_valid), 64'd0);
        check("arst.idle", 64'(busy), 64'd0);
        $display("[TB] async reset mid-op applied and released");

        // Post-reset: req0 must win first; three ops with two stall cycles total
        set_req(0, 32'd3, 32'd5, 3'd0, 7'h20, 7'h33);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'd0, 7'h00, 7'h33);
        run_op("post0", 0, 2'b01, 32'd3, 32'hFFFF_FFFE, 1'b0, 1, 1'b1);
        run_op("post1", 1, 2'b10, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b1);
        set_req(0, 32'd2, 32'd3, 3'd0, 7'h00, 7'h33);
        run_op("post2", 0, 2'b01, 32'd2, 32'd5, 1'b0, 0, 1'b1);
`ifdef ALU_ARB_STATS_EN
        check("stat_ops", 64'(stat_ops), 64'd3);
        check("stat_stall", 64'(stat_stall), 64'd2);
        $display("[TB] stats ops=%0d stall=%0d", stat_ops, stat_stall);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
